// File: rtl/mux_nch_reg.sv
// mux_nch_reg: N-channel registered mux with valid/ready, direct-select or round-robin scan.
// Optional MUXN_SEL_ERR_EN adds a sticky err output for out-of-range sel in direct mode.
module mux_nch_reg #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef MUXN_SEL_ERR_EN
    ,
    output logic                 err
`endif
);
    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);
    logic [SELW-1:0]  ptr, ptr_nxt, cur;
    logic [NCH-1:0]   hit;
    logic [WIDTH-1:0] cur_data;
    logic             load;
    assign load = !out_valid || out_ready;
    assign cur  = mode ? ptr : sel;
    // one-hot decode of cur; an out-of-range cur leaves hit all-zero
    always_comb begin
        hit      = '0;
        cur_data = '0;
        for (int k = 0; k < NCH; k++)
            if (cur == SELW'(k)) begin
                hit[k]   = 1'b1;
                cur_data = din[k*WIDTH +: WIDTH];
            end
    end
    assign in_ready = load ? hit : '0;
    assign ptr_nxt  = !mode ? sel : !load ? ptr : (ptr >= LAST) ? '0 : ptr + SELW'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            ptr <= ptr_nxt;
            if (load) begin
                out_data  <= cur_data;
                out_ch    <= cur;
                out_valid <= |(hit & in_valid);
            end
        end
    end
`ifdef MUXN_SEL_ERR_EN
    logic sel_bad;
    assign sel_bad = !mode && ({1'b0, sel} >= (SELW+1)'(NCH));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= err | sel_bad;
    end
`endif
endmodule

// File: tb/tb_mux_nch_reg.sv
// tb_mux_nch_reg: directed and random stimulus for mux_nch_reg against a behavioural model.
module tb_mux_nch_reg;
    localparam int W = 8;
    localparam int N = 3;
    localparam int S = 2;
    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] din;
    logic [N-1:0]   in_valid, in_ready;
    logic [S-1:0]   sel, out_ch;
    logic           mode, out_valid, out_ready;
    logic [W-1:0]   out_data;
`ifdef MUXN_SEL_ERR_EN
    logic           err;
`endif
    always #5 clk = ~clk;

    mux_nch_reg #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
        .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUXN_SEL_ERR_EN
        , .err(err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int m_ptr, m_ch, m_valid, m_err;
    logic [W-1:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_ch = 0; m_valid = 0; m_err = 0; m_data = '0;
    endtask

    task automatic check_out();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
        if (m_valid != 0) chk("out_data", 32'(out_data), 32'(m_data));
`ifdef MUXN_SEL_ERR_EN
        chk("err", 32'(err), 32'(m_err));
`endif
    endtask

    // inputs are already applied; check in_ready, clock once, update model, check outputs
    task automatic cycle();
        int cur;
        bit load;
        logic [N-1:0] er;
        #1;
        cur  = mode ? m_ptr : int'(sel);
        load = (m_valid == 0) || out_ready;
        er   = '0;
        if (load && cur < N) er[cur] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(er));
        @(posedge clk);
        if (!mode && sel >= N) m_err = 1;
        if (load) begin
            m_ch    = cur;
            m_valid = (cur < N && in_valid[cur]) ? 1 : 0;
            if (cur < N) m_data = din[cur*W +: W];
        end
        if (!mode) m_ptr = int'(sel);
        else if (load) m_ptr = (m_ptr == N-1) ? 0 : (m_ptr + 1) % (1 << S);
        #1;
        check_out();
    endtask

    initial begin
        rst = 1'b1; din = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out();
        rst = 1'b0;

        // direct transfer from channel 2
        sel = 2'd2; din = {8'hA5, 8'h00, 8'h00}; in_valid = 3'b100; out_ready = 1'b1;
        cycle();
        chk("direct_data", 32'(out_data), 32'h0A5);

        // backpressure: held beat must not move while din changes
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = N*W'($urandom);
            cycle();
            chk("bp_hold", 32'(out_data), 32'h0A5);
        end
        out_ready = 1'b1; sel = 2'd0; in_valid = 3'b001; din = {8'h00, 8'h00, 8'h3C};
        cycle();

        // scan wrap starting from sel=1
        sel = 2'd1; in_valid = 3'b000;
        cycle();
        mode = 1'b1; in_valid = 3'b111; din = {8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 4; i++) cycle();

        // scan skip: channel 1 idle gives one bubble per rotation
        in_valid = 3'b101;
        for (int i = 0; i < 6; i++) cycle();

        // out-of-range select in direct mode
        mode = 1'b0; sel = 2'd3; in_valid = 3'b111;
        repeat (2) cycle();
        sel = 2'd0;
        cycle();

        // asynchronous reset while a beat is held
        in_valid = 3'b001; out_ready = 1'b0;
        cycle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_out();
        @(posedge clk);
        #1 rst = 1'b0;
        mode = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            din       = N*W'({$urandom, $urandom});
            in_valid  = N'($urandom);
            sel       = S'($urandom);
            mode      = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
